// File: rtl/sequenciador_varredura_if.sv
// Control and select bundle between the scan sequencer and the
// block that commands it.
interface sequenciador_varredura_if;
    logic       start;
    logic       stop;
    logic       dir;
    logic       continuo;
    logic [2:0] a;
    logic       en;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output stop,
        output dir,
        output continuo,
        input  a,
        input  en,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  stop,
        input  dir,
        input  continuo,
        output a,
        output en,
        output busy,
        output done
    );
endinterface

// File: rtl/sequenciador_varredura.sv
// Scan sequencer: walks the 3-to-8 decoder select through all eight
// positions, holding each for DWELL cycles, up or down, once or looping.
module sequenciador_varredura #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    sequenciador_varredura_if.slave    bus
);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       a, a_n;
    logic             en, en_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             dir_q, dir_n;
    logic             cont_q, cont_n;
    logic             at_end;

    // Last position depends on the latched direction, not the live input.
    assign at_end = dir_q ? (a == 3'd0) : (a == 3'd7);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = a;
        en_n    = en;
        busy_n  = busy;
        done_n  = 1'b0;
        dir_n   = dir_q;
        cont_n  = cont_q;
        unique case (state)
            IDLE: begin
                en_n   = 1'b0;
                busy_n = 1'b0;
                if (bus.start && !bus.stop) begin
                    dir_n   = bus.dir;
                    cont_n  = bus.continuo;
                    a_n     = bus.dir ? 3'd7 : 3'd0;
                    en_n    = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (bus.stop) begin
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (at_end && !cont_q) begin
                        en_n    = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else if (dir_q) begin
                        a_n = a - 3'd1;
                    end else begin
                        a_n = a + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a      <= 3'd0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dir_q  <= 1'b0;
            cont_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            a      <= a_n;
            en     <= en_n;
            busy   <= busy_n;
            done   <= done_n;
            dir_q  <= dir_n;
            cont_q <= cont_n;
        end
    end

    assign bus.a    = a;
    assign bus.en   = en;
    assign bus.busy = busy;
    assign bus.done = done;

endmodule
